// File: rtl/riscv_dp_storeenc.sv
// Store encoder: places rs2 bytes on data-memory lanes and runs the write handshake.
// Optional RISCV_STORE_SPLIT_EN issues word-crossing stores as two beats.
module riscv_dp_storeenc #(
    parameter int MP_DATA_WIDTH = 32,
    parameter int MP_ADDR_WIDTH = 32
) (
    input  logic                     iclk,
    input  logic                     irst_n,
    input  logic                     ivalid,
    output logic                     oready,
    input  logic [MP_ADDR_WIDTH-1:0] iaddr,
    input  logic [2:0]               ifunct3,
    input  logic [MP_DATA_WIDTH-1:0] iwdata,
    output logic                     odmem_req,
    output logic [MP_ADDR_WIDTH-1:0] odmem_addr,
    output logic [MP_DATA_WIDTH-1:0] odmem_wdata,
    output logic [3:0]               odmem_be,
    input  logic                     idmem_ack,
    output logic                     odone,
    output logic                     oerr
);

    localparam int DW = MP_DATA_WIDTH;
    localparam int AW = MP_ADDR_WIDTH;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BEAT0 = 2'd1;
`ifdef RISCV_STORE_SPLIT_EN
    localparam logic [1:0] S_BEAT1 = 2'd2;
`endif

    logic [1:0]    state_q, state_d;
    logic          ready_q, ready_d;
    logic          req_q, req_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          legal;
    logic [3:0]    mask;
    logic [DW-1:0] sized;
    logic [4:0]    sh_amt;
    logic [7:0]    be_all;
    logic          need2;
    logic [DW-1:0] lo_data;
    logic [AW-1:0] a0;

    always_comb begin
        legal = 1'b1;
        mask  = 4'b0000;
        sized = '0;
        case (ifunct3)
            3'b000: begin
                mask  = 4'b0001;
                sized = {{(DW-8){1'b0}}, iwdata[7:0]};
            end
            3'b001: begin
                mask  = 4'b0011;
                sized = {{(DW-16){1'b0}}, iwdata[15:0]};
            end
            3'b010: begin
                mask  = 4'b1111;
                sized = iwdata;
            end
            default: legal = 1'b0;
        endcase
    end

    assign sh_amt  = {iaddr[1:0], 3'b000};
    assign be_all  = {4'b0000, mask} << iaddr[1:0];
    assign need2   = |be_all[7:4];
    assign lo_data = sized << sh_amt;
    assign a0      = {iaddr[AW-1:2], 2'b00};

`ifdef RISCV_STORE_SPLIT_EN
    logic [DW-1:0] hi_data;
    logic [AW-1:0] a1;
    logic [AW-1:0] b1_addr_q, b1_addr_d;
    logic [DW-1:0] b1_wdata_q, b1_wdata_d;
    logic [3:0]    b1_be_q, b1_be_d;
    logic          b1_vld_q, b1_vld_d;

    // Shift by 32 at offset 0 yields zero, so hi_data needs no special case.
    assign hi_data = sized >> (6'd32 - {1'b0, sh_amt});
    assign a1      = a0 + AW'(4);
`endif

    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        req_d   = req_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef RISCV_STORE_SPLIT_EN
        b1_addr_d  = b1_addr_q;
        b1_wdata_d = b1_wdata_q;
        b1_be_d    = b1_be_q;
        b1_vld_d   = b1_vld_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ivalid) begin
`ifdef RISCV_STORE_SPLIT_EN
                    if (!legal) begin
`else
                    if (!legal || need2) begin
`endif
                        err_d = 1'b1;
                    end else begin
                        state_d = S_BEAT0;
                        ready_d = 1'b0;
                        req_d   = 1'b1;
                        addr_d  = a0;
                        wdata_d = lo_data;
                        be_d    = be_all[3:0];
`ifdef RISCV_STORE_SPLIT_EN
                        b1_addr_d  = a1;
                        b1_wdata_d = hi_data;
                        b1_be_d    = be_all[7:4];
                        b1_vld_d   = need2;
`endif
                    end
                end
            end
            S_BEAT0: begin
                if (idmem_ack) begin
`ifdef RISCV_STORE_SPLIT_EN
                    if (b1_vld_q) begin
                        state_d = S_BEAT1;
                        addr_d  = b1_addr_q;
                        wdata_d = b1_wdata_q;
                        be_d    = b1_be_q;
                    end else begin
`else
                    begin
`endif
                        state_d = S_IDLE;
                        ready_d = 1'b1;
                        req_d   = 1'b0;
                        addr_d  = '0;
                        wdata_d = '0;
                        be_d    = 4'b0000;
                        done_d  = 1'b1;
                    end
                end
            end
`ifdef RISCV_STORE_SPLIT_EN
            S_BEAT1: begin
                if (idmem_ack) begin
                    state_d  = S_IDLE;
                    ready_d  = 1'b1;
                    req_d    = 1'b0;
                    addr_d   = '0;
                    wdata_d  = '0;
                    be_d     = 4'b0000;
                    done_d   = 1'b1;
                    b1_vld_d = 1'b0;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                req_d   = 1'b0;
                addr_d  = '0;
                wdata_d = '0;
                be_d    = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            req_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= 4'b0000;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

`ifdef RISCV_STORE_SPLIT_EN
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            b1_addr_q  <= '0;
            b1_wdata_q <= '0;
            b1_be_q    <= 4'b0000;
            b1_vld_q   <= 1'b0;
        end else begin
            b1_addr_q  <= b1_addr_d;
            b1_wdata_q <= b1_wdata_d;
            b1_be_q    <= b1_be_d;
            b1_vld_q   <= b1_vld_d;
        end
    end
`endif

    assign oready      = ready_q;
    assign odmem_req   = req_q;
    assign odmem_addr  = addr_q;
    assign odmem_wdata = wdata_q;
    assign odmem_be    = be_q;
    assign odone       = done_q;
    assign oerr        = err_q;

endmodule

// File: tb/tb_riscv_dp_storeenc.sv
// Bench for riscv_dp_storeenc: directed plan cases plus random stores
// against a byte-lane reference model.
module tb_riscv_dp_storeenc;

    logic        iclk;
    logic        irst_n;
    logic        ivalid;
    logic        oready;
    logic [31:0] iaddr;
    logic [2:0]  ifunct3;
    logic [31:0] iwdata;
    logic        odmem_req;
    logic [31:0] odmem_addr;
    logic [31:0] odmem_wdata;
    logic [3:0]  odmem_be;
    logic        idmem_ack;
    logic        odone;
    logic        oerr;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_a[2];
    logic [31:0] exp_d[2];
    logic [3:0]  exp_be[2];

    riscv_dp_storeenc #(
        .MP_DATA_WIDTH(32),
        .MP_ADDR_WIDTH(32)
    ) dut (
        .iclk       (iclk),
        .irst_n     (irst_n),
        .ivalid     (ivalid),
        .oready     (oready),
        .iaddr      (iaddr),
        .ifunct3    (ifunct3),
        .iwdata     (iwdata),
        .odmem_req  (odmem_req),
        .odmem_addr (odmem_addr),
        .odmem_wdata(odmem_wdata),
        .odmem_be   (odmem_be),
        .idmem_ack  (idmem_ack),
        .odone      (odone),
        .oerr       (oerr)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    // Byte-by-byte placement: byte i of rs2 goes to global lane off+i.
    task automatic model(input logic [31:0] a, input logic [2:0] f3,
                         input logic [31:0] d, output bit err,
                         output int nb);
        int n;
        int lane;
        n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
        for (int b = 0; b < 2; b++) begin
            exp_d[b]  = '0;
            exp_be[b] = '0;
        end
        for (int i = 0; i < n; i++) begin
            lane = int'(a[1:0]) + i;
            exp_d[lane/4][8*(lane%4) +: 8] = d[8*i +: 8];
            exp_be[lane/4][lane%4] = 1'b1;
        end
        exp_a[0] = a & 32'hFFFF_FFFC;
        exp_a[1] = exp_a[0] + 32'd4;
        nb  = (exp_be[1] != 4'd0) ? 2 : 1;
        err = (n == 0);
`ifndef RISCV_STORE_SPLIT_EN
        if (nb == 2) err = 1'b1;
`endif
    endtask

    task automatic run_store(input logic [31:0] a, input logic [2:0] f3,
                             input logic [31:0] d, input int dly,
                             input bit junk, input bit chain,
                             input string nm);
        bit err;
        int nb;
        model(a, f3, d, err, nb);
        n_cmp++;
        if (oready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s ready_before: got %b want 1", nm, oready);
        end
        ivalid  = 1'b1;
        iaddr   = a;
        ifunct3 = f3;
        iwdata  = d;
        @(posedge iclk); #1;
        ivalid = 1'b0;
        iaddr  = $urandom;
        iwdata = $urandom;
        if (err) begin
            n_cmp++;
            if ({oerr, odone, odmem_req, oready, odmem_be} !== 8'b1001_0000) begin
                n_bad++;
                $display("FAIL %s err_pulse: got err=%b done=%b req=%b rdy=%b be=%b want 1 0 0 1 0000",
                         nm, oerr, odone, odmem_req, oready, odmem_be);
            end
            if (!chain) begin
                @(posedge iclk); #1;
                n_cmp++;
                if ({oerr, odone, odmem_req} !== 3'b000) begin
                    n_bad++;
                    $display("FAIL %s err_drop: got err=%b done=%b req=%b want 000",
                             nm, oerr, odone, odmem_req);
                end
            end
            return;
        end
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c <= dly; c++) begin
                n_cmp++;
                if ({odmem_req, odmem_addr, odmem_wdata, odmem_be, oready, odone, oerr}
                    !== {1'b1, exp_a[b], exp_d[b], exp_be[b], 3'b000}) begin
                    n_bad++;
                    $display("FAIL %s beat%0d cyc%0d: got req=%b a=%h d=%h be=%b rdy=%b dn=%b er=%b want 1 a=%h d=%h be=%b 0 0 0",
                             nm, b, c, odmem_req, odmem_addr, odmem_wdata, odmem_be,
                             oready, odone, oerr, exp_a[b], exp_d[b], exp_be[b]);
                end
                if (c < dly) begin
                    if (junk) begin
                        ivalid  = 1'b1;
                        iaddr   = $urandom;
                        ifunct3 = 3'($urandom_range(0, 2));
                        iwdata  = $urandom;
                    end
                    @(posedge iclk); #1;
                end
            end
            ivalid    = 1'b0;
            idmem_ack = 1'b1;
            @(posedge iclk); #1;
            idmem_ack = 1'b0;
        end
        n_cmp++;
        if ({odmem_req, odmem_be, odmem_wdata, odone, oready, oerr}
            !== {1'b0, 4'b0, 32'b0, 3'b110}) begin
            n_bad++;
            $display("FAIL %s complete: got req=%b be=%b d=%h dn=%b rdy=%b er=%b want 0 0000 0 1 1 0",
                     nm, odmem_req, odmem_be, odmem_wdata, odone, oready, oerr);
        end
        if (!chain) begin
            @(posedge iclk); #1;
            n_cmp++;
            if ({odone, oerr, odmem_req, oready} !== 4'b0001) begin
                n_bad++;
                $display("FAIL %s done_drop: got dn=%b er=%b req=%b rdy=%b want 0 0 0 1",
                         nm, odone, oerr, odmem_req, oready);
            end
        end
    endtask

    task automatic test_reset();
        irst_n    = 1'b0;
        ivalid    = 1'b0;
        iaddr     = '0;
        ifunct3   = '0;
        iwdata    = '0;
        idmem_ack = 1'b0;
        repeat (2) @(posedge iclk);
        #1;
        n_cmp++;
        if ({oready, odmem_req, odmem_addr, odmem_wdata, odmem_be, odone, oerr}
            !== {1'b1, 1'b0, 32'b0, 32'b0, 4'b0, 2'b00}) begin
            n_bad++;
            $display("FAIL reset_vals: got rdy=%b req=%b a=%h d=%h be=%b dn=%b er=%b",
                     oready, odmem_req, odmem_addr, odmem_wdata, odmem_be, odone, oerr);
        end
        irst_n = 1'b1;
        @(posedge iclk); #1;
        n_cmp++;
        if ({oready, odmem_req, odone, oerr} !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset_release: got rdy=%b req=%b dn=%b er=%b want 1000",
                     oready, odmem_req, odone, oerr);
        end
    endtask

    task automatic test_plan();
        run_store(32'h0000_1003, 3'b000, 32'hAABB_CCDD, 0, 1'b0, 1'b0, "sb_lane3");
        run_store(32'h0000_2002, 3'b001, 32'h1234_5678, 3, 1'b1, 1'b0, "sh_stall");
        run_store(32'h0000_2003, 3'b001, 32'h0000_BEEF, 0, 1'b0, 1'b0, "sh_cross");
        run_store(32'hFFFF_FFFD, 3'b010, 32'h1122_3344, 1, 1'b0, 1'b0, "sw_wrap");
        run_store(32'h0000_2001, 3'b001, 32'h0000_A55A, 0, 1'b0, 1'b0, "sh_off1");
        run_store(32'h0000_1234, 3'b011, 32'h0BAD_0BAD, 0, 1'b0, 1'b0, "illegal");
        run_store(32'h0000_0040, 3'b010, 32'hCAFE_F00D, 0, 1'b0, 1'b0, "sw_align");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            run_store($urandom, 3'($urandom_range(0, 2)), $urandom,
                      0, 1'b0, (i != 7), "b2b");
        end
    endtask

    task automatic test_random();
        logic [2:0] f3;
        for (int i = 0; i < 60; i++) begin
            f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7))
                                             : 3'($urandom_range(0, 2));
            run_store($urandom, f3, $urandom, int'($urandom_range(0, 2)),
                      bit'($urandom_range(0, 1)), 1'b0, "rand");
        end
    endtask

    task automatic test_reset_mid();
`ifdef RISCV_STORE_SPLIT_EN
        ivalid  = 1'b1;
        iaddr   = 32'h0000_2003;
        ifunct3 = 3'b001;
        iwdata  = 32'h0000_BEEF;
        @(posedge iclk); #1;
        ivalid    = 1'b0;
        idmem_ack = 1'b1;
        @(posedge iclk); #1;
        idmem_ack = 1'b0;
        n_cmp++;
        if ({odmem_req, odmem_be} !== 5'b1_0001) begin
            n_bad++;
            $display("FAIL rstmid_beat1: got req=%b be=%b want 1 0001", odmem_req, odmem_be);
        end
`else
        ivalid  = 1'b1;
        iaddr   = 32'h0000_0040;
        ifunct3 = 3'b010;
        iwdata  = 32'hCAFE_F00D;
        @(posedge iclk); #1;
        ivalid = 1'b0;
        n_cmp++;
        if ({odmem_req, odmem_be} !== 5'b1_1111) begin
            n_bad++;
            $display("FAIL rstmid_beat0: got req=%b be=%b want 1 1111", odmem_req, odmem_be);
        end
`endif
        #2;
        irst_n = 1'b0;
        #1;
        n_cmp++;
        if ({odmem_req, odmem_be, odmem_wdata, oready, odone, oerr}
            !== {1'b0, 4'b0, 32'b0, 3'b100}) begin
            n_bad++;
            $display("FAIL rstmid_async: got req=%b be=%b d=%h rdy=%b dn=%b er=%b",
                     odmem_req, odmem_be, odmem_wdata, oready, odone, oerr);
        end
        @(posedge iclk); #3;
        irst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge iclk); #1;
            n_cmp++;
            if ({oready, odmem_req, odone, oerr} !== 4'b1000) begin
                n_bad++;
                $display("FAIL rstmid_after%0d: got rdy=%b req=%b dn=%b er=%b want 1000",
                         i, oready, odmem_req, odone, oerr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_plan();
        test_back_to_back();
        test_random();
        test_reset_mid();
        run_store(32'h0000_0101, 3'b000, 32'h0000_007E, 0, 1'b0, 1'b0, "post_rst");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
